decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: none; widths fixed (32-bit data, 5-bit register numbers).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  IF/ID holds a valid instruction.
REQ-005 in_ready  out  1  decode accepts in_instr/in_pc this cycle.
REQ-006 in_instr  in  32  DLX instruction word.
REQ-007 in_pc  in  32  PC of in_instr.
REQ-008 rs1, rs2, rs3  out  5 each  read-port numbers to the register file (combinational from in_instr).
REQ-009 s1, s2, s3  in  32 each  register-file read data for rs1/rs2/rs3, same cycle.
REQ-010 out_valid  out  1  ID/EX register holds a valid instruction.
REQ-011 out_ready  in  1  EX stage accepts ID/EX contents this cycle.
REQ-012 out_a, out_b, out_c  out  32 each  captured s1, s2, s3 (out_c = store data).
REQ-013 out_imm  out  32  extended immediate.
REQ-014 out_rd  out  5  destination register; 0 = no writeback.
REQ-015 out_opcode, out_func  out  6 each  instr[31:26], instr[5:0].
REQ-016 out_is_load, out_is_store  out  1 each  class flags.
REQ-017 out_pc  out  32  captured in_pc.
REQ-018 stall_cnt  out  16  saturating count of hazard bubble cycles.

Function
REQ-019 Decode SHALL be: opcode 0x00 R-type: rs1=[25:21], rs2=[20:16], rs3=0, rd=[15:11].
REQ-020 Opcodes 0x02 (J), 0x03 (JAL) J-type: rs1=rs2=rs3=0; rd=31 for JAL, else 0; imm = sign-extended [25:0].
REQ-021 Stores 0x28-0x2B: rs1=[25:21], rs3=[20:16], rs2=0, rd=0, out_is_store=1.
REQ-022 Branches 0x04/0x05, jump-register 0x12/0x13: rs1=[25:21], rs2=rs3=0; rd=0 except JALR (0x13) rd=31.
REQ-023 All other opcodes I-type: rs1=[25:21], rs2=rs3=0, rd=[20:16]; loads 0x20-0x25 set out_is_load=1.
REQ-024 imm16 SHALL be zero-extended for 0x0C, 0x0D, 0x0E, 0x0F (LHI), sign-extended otherwise.
REQ-025 in_ready = (!out_valid | out_ready) & !hazard.
REQ-026 Fire = in_valid & in_ready; on fire ID/EX loads all out_* next edge (latency 1 cycle).
REQ-027 If (!out_valid | out_ready) and no fire, out_valid SHALL clear next edge (bubble); other out_* don't-care but SHALL hold.
REQ-028 If out_valid & !out_ready, ID/EX SHALL hold all fields unchanged.
REQ-029 Any rs field value 0 SHALL never cause a hazard; out_rd=0 SHALL never match.
REQ-030 stall_cnt SHALL increment by 1 on each cycle with hazard & out_ready & in_valid, saturating at 0xFFFF.

Reset
REQ-031 On reset: out_valid=0, out_a/out_b/out_c/out_imm/out_pc=0, out_rd=0, out_opcode/out_func=0, out_is_load=out_is_store=0, stall_cnt=0.
REQ-032 Reset mid-stall SHALL drop the held instruction; first edge after reset deassertion accepts new input.

Configuration
REQ-033 Macro DECODE_LOAD_STALL_EN defined: hazard = in_valid & out_valid & out_is_load & out_rd!=0 & out_rd in {rs1,rs2,rs3}; one bubble inserted, then dependent instruction proceeds.
REQ-034 Macro undefined: hazard is constant 0, no bubbles, stall_cnt stays 0 (load-use scheduling left to compiler).

Verification
REQ-035 ADD r3,r1,r2 (0x00221820), s1=5, s2=7, out_ready=1 -> next cycle out_valid=1, out_a=5, out_b=7, out_rd=3.
REQ-036 ADDI r4,r0,-1 (0x2004FFFF) -> out_imm=0xFFFFFFFF, rd=4; ORI r4,r0,0xFFFF (0x3404FFFF) -> out_imm=0x0000FFFF.
REQ-037 LW r5,0(r1) then ADD r6,r5,r2, MACRO on -> one bubble (out_valid=0 one cycle), in_ready=0 one cycle, stall_cnt=1; MACRO off -> back-to-back, stall_cnt=0.
REQ-038 SW r7,8(r1) (0xAC270008) -> rs1=1, rs3=7, out_c=s3, out_rd=0, out_is_store=1; JAL -> out_rd=31.
REQ-039 out_ready=0 for 3 cycles with valid ID/EX -> outputs stable, in_ready=0; reset asserted in cycle 2 -> out_valid=0 next edge.

Source files
------------

// File: rtl/decode_stage.sv
// DLX decode stage: field extraction, immediate extension and an elastic ID/EX register.
// Optional load-use interlock is enabled by defining DECODE_LOAD_STALL_EN.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rs3,
  input  logic [31:0] s1,
  input  logic [31:0] s2,
  input  logic [31:0] s3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_c,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [5:0]  out_opcode,
  output logic [5:0]  out_func,
  output logic        out_is_load,
  output logic        out_is_store,
  output logic [31:0] out_pc,
  output logic [15:0] stall_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_JALR  = 6'h13;

  logic [5:0]  opcode;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        is_load;
  logic        is_store;
  logic        hazard;
  logic        advance;
  logic        fire;

  assign opcode = in_instr[31:26];

  // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
  always_comb begin
    rs1      = in_instr[25:21];
    rs2      = 5'd0;
    rs3      = 5'd0;
    rd       = in_instr[20:16];
    is_load  = 1'b0;
    is_store = 1'b0;
    if (opcode inside {6'h0C, 6'h0D, 6'h0E, 6'h0F})
      imm = {16'd0, in_instr[15:0]};
    else
      imm = {{16{in_instr[15]}}, in_instr[15:0]};

    unique case (opcode) inside
      OP_RTYPE: begin
        rs2 = in_instr[20:16];
        rd  = in_instr[15:11];
      end
      OP_J, OP_JAL: begin
        rs1 = 5'd0;
        rd  = (opcode == OP_JAL) ? 5'd31 : 5'd0;
        imm = {{6{in_instr[25]}}, in_instr[25:0]};
      end
      [6'h28:6'h2B]: begin
        rs3      = in_instr[20:16];
        rd       = 5'd0;
        is_store = 1'b1;
      end
      6'h04, 6'h05, 6'h12, OP_JALR: begin
        rd = (opcode == OP_JALR) ? 5'd31 : 5'd0;
      end
      default: begin
        is_load = (opcode inside {[6'h20:6'h25]});
      end
    endcase
  end

`ifdef DECODE_LOAD_STALL_EN
  // out_rd != 0 already guarantees that a zero rs field can never match.
  assign hazard = in_valid & out_valid & out_is_load & (out_rd != 5'd0) &
                  ((out_rd == rs1) | (out_rd == rs2) | (out_rd == rs3));
`else
  assign hazard = 1'b0;
`endif

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & ~hazard;
  assign fire     = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_c        <= '0;
      out_imm      <= '0;
      out_rd       <= '0;
      out_opcode   <= '0;
      out_func     <= '0;
      out_is_load  <= 1'b0;
      out_is_store <= 1'b0;
      out_pc       <= '0;
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_a        <= s1;
      out_b        <= s2;
      out_c        <= s3;
      out_imm      <= imm;
      out_rd       <= rd;
      out_opcode   <= opcode;
      out_func     <= in_instr[5:0];
      out_is_load  <= is_load;
      out_is_store <= is_store;
      out_pc       <= in_pc;
    end else if (advance) begin
      out_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (hazard & out_ready & in_valid & (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic checked against a behavioural model.
module tb_decode_stage;

`ifdef DECODE_LOAD_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1, rs2, rs3;
  logic [31:0] s1, s2, s3;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a, out_b, out_c, out_imm, out_pc;
  logic [4:0]  out_rd;
  logic [5:0]  out_opcode, out_func;
  logic        out_is_load, out_is_store;
  logic [15:0] stall_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .s1(s1), .s2(s2), .s3(s3), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_imm(out_imm), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_func(out_func), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_pc(out_pc), .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [4:0]  rs1, rs2, rs3, rd;
    logic [31:0] imm;
    logic        ld, st;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    dec_t        d;
  } vec_t;

  typedef struct {
    logic        valid;
    dec_t        d;
    logic [31:0] a, b, c, pc, instr;
  } idex_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Reference decode written from the instruction-class table.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t r;
    int op;
    op = int'(w[31:26]);
    r.ld = 1'b0; r.st = 1'b0;
    r.rs1 = w[25:21]; r.rs2 = 5'd0; r.rs3 = 5'd0; r.rd = w[20:16];
    r.imm = (op >= 12 && op <= 15) ? {16'd0, w[15:0]} : 32'($signed(w[15:0]));
    if (op == 0) begin
      r.rs2 = w[20:16]; r.rd = w[15:11];
    end else if (op == 2 || op == 3) begin
      r.rs1 = 5'd0;
      r.rd  = (op == 3) ? 5'd31 : 5'd0;
      r.imm = 32'($signed(w[25:0]));
    end else if (op >= 'h28 && op <= 'h2B) begin
      r.rs3 = w[20:16]; r.rd = 5'd0; r.st = 1'b1;
    end else if (op == 4 || op == 5 || op == 'h12 || op == 'h13) begin
      r.rd = (op == 'h13) ? 5'd31 : 5'd0;
    end else begin
      r.ld = (op >= 'h20 && op <= 'h25);
    end
    return r;
  endfunction

  vec_t vecs[10];
  idex_t m;
  dec_t  rd_ref;
  logic [31:0] held_a;
  logic [4:0]  held_rd;
  logic        m_ready, m_haz;
  int          m_stall;
  logic [5:0]  ops[16];

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; s1 = '0; s2 = '0; s3 = '0;

    vecs[0] = '{32'h00221820, '{5'd1, 5'd2, 5'd0, 5'd3,  32'h00001820, 1'b0, 1'b0}}; // ADD r3,r1,r2
    vecs[1] = '{32'h2004FFFF, '{5'd0, 5'd0, 5'd0, 5'd4,  32'hFFFFFFFF, 1'b0, 1'b0}}; // ADDI r4,r0,-1
    vecs[2] = '{32'h3404FFFF, '{5'd0, 5'd0, 5'd0, 5'd4,  32'h0000FFFF, 1'b0, 1'b0}}; // ORI r4,r0,0xFFFF
    vecs[3] = '{32'hAC270008, '{5'd1, 5'd0, 5'd7, 5'd0,  32'h00000008, 1'b0, 1'b1}}; // SW r7,8(r1)
    vecs[4] = '{32'h0FFFFFFC, '{5'd0, 5'd0, 5'd0, 5'd31, 32'hFFFFFFFC, 1'b0, 1'b0}}; // JAL -4
    vecs[5] = '{32'h08000010, '{5'd0, 5'd0, 5'd0, 5'd0,  32'h00000010, 1'b0, 1'b0}}; // J +16
    vecs[6] = '{32'h8C250000, '{5'd1, 5'd0, 5'd0, 5'd5,  32'h00000000, 1'b1, 1'b0}}; // LW r5,0(r1)
    vecs[7] = '{32'h3C098000, '{5'd0, 5'd0, 5'd0, 5'd9,  32'h00008000, 1'b0, 1'b0}}; // LHI r9,0x8000
    vecs[8] = '{32'h4C400000, '{5'd2, 5'd0, 5'd0, 5'd31, 32'h00000000, 1'b0, 1'b0}}; // JALR r2
    vecs[9] = '{32'h10A0FFFC, '{5'd5, 5'd0, 5'd0, 5'd0,  32'hFFFFFFFC, 1'b0, 1'b0}}; // BEQZ r5,-4

    do_reset();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_flags", {out_rd, out_opcode, out_func, out_is_load, out_is_store}, 0);
    check("rst_stall_cnt", 32'(stall_cnt), 0);

    // Directed decode table, one instruction per cycle with EX always ready.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(4 * i);
      s1 = 32'(5 + 16 * i); s2 = 32'(7 + 16 * i); s3 = 32'hDEAD0000 | 32'(i);
      #1;
      check($sformatf("v%0d_rs", i), {rs1, rs2, rs3}, {vecs[i].d.rs1, vecs[i].d.rs2, vecs[i].d.rs3});
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 1);
      tick();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 1);
      check($sformatf("v%0d_abc", i), out_a ^ out_b ^ out_c,
            32'(5 + 16 * i) ^ 32'(7 + 16 * i) ^ (32'hDEAD0000 | 32'(i)));
      check($sformatf("v%0d_a", i), out_a, 32'(5 + 16 * i));
      check($sformatf("v%0d_c", i), out_c, 32'hDEAD0000 | 32'(i));
      check($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].d.rd));
      check($sformatf("v%0d_imm", i), out_imm, vecs[i].d.imm);
      check($sformatf("v%0d_ldst", i), {out_is_load, out_is_store}, {vecs[i].d.ld, vecs[i].d.st});
      check($sformatf("v%0d_opfn", i), {out_opcode, out_func}, {vecs[i].instr[31:26], vecs[i].instr[5:0]});
      check($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(4 * i));
    end

    // Load-use: LW r5,0(r1) followed by ADD r6,r5,r2.
    do_reset();
    in_valid = 1'b1; in_instr = 32'h8C250000; s1 = 32'h11; s2 = 32'h22; s3 = 32'h33;
    tick();
    in_instr = 32'h00A23020; s1 = 32'h55; s2 = 32'h66;
    #1;
    check("lu_in_ready", 32'(in_ready), STALL_EN ? 0 : 1);
    tick();
    check("lu_valid1", 32'(out_valid), STALL_EN ? 0 : 1);
    check("lu_rd1", 32'(out_rd), STALL_EN ? 5 : 6);
    check("lu_stall1", 32'(stall_cnt), STALL_EN ? 1 : 0);
    in_valid = STALL_EN;
    #1;
    check("lu_in_ready2", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("lu_valid2", 32'(out_valid), STALL_EN ? 1 : 0);
    check("lu_rd2", 32'(out_rd), 6);
    check("lu_a2", out_a, 32'h55);
    check("lu_stall2", 32'(stall_cnt), STALL_EN ? 1 : 0);

    // Back-pressure hold, then reset in the middle of the stall.
    do_reset();
    in_valid = 1'b1; in_instr = 32'h00221820; s1 = 32'd5; s2 = 32'd7; in_pc = 32'h40;
    tick();
    held_a = out_a; held_rd = out_rd;
    out_ready = 1'b0; in_instr = 32'h2004FFFF; s1 = 32'h99;
    #1;
    check("bp_in_ready1", 32'(in_ready), 0);
    tick();
    check("bp_hold_valid", 32'(out_valid), 1);
    check("bp_hold_a", out_a, 32'd5);
    check("bp_hold_rd", 32'(out_rd), 3);
    check("bp_in_ready2", 32'(in_ready), 0);
    reset = 1'b1;
    tick();
    check("bp_rst_valid", 32'(out_valid), 0);
    check("bp_rst_a", out_a, 0);
    reset = 1'b0;
    #1;
    check("bp_post_ready", 32'(in_ready), 1);
    tick();
    check("bp_post_valid", 32'(out_valid), 1);
    check("bp_post_imm", out_imm, 32'hFFFFFFFF);
    check("bp_post_a", out_a, 32'h99);

    // Randomized traffic against the behavioural model.
    ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D,
            6'h0F, 6'h12, 6'h13, 6'h20, 6'h23, 6'h25, 6'h28, 6'h2B};
    do_reset();
    m = '{valid: 1'b0, d: '{5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 1'b0},
          a: '0, b: '0, c: '0, pc: '0, instr: '0};
    m_stall = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = $urandom;
      if ($urandom_range(0, 3) != 0) in_instr[31:26] = ops[$urandom_range(0, 15)];
      if ($urandom_range(0, 2) == 0) in_instr[25:16] = {m.d.rd, m.d.rd};
      in_pc = $urandom; s1 = $urandom; s2 = $urandom; s3 = $urandom;
      rd_ref = ref_decode(in_instr);
      m_haz = STALL_EN && in_valid && m.valid && m.d.ld && m.d.rd != 0 &&
              (m.d.rd == rd_ref.rs1 || m.d.rd == rd_ref.rs2 || m.d.rd == rd_ref.rs3);
      m_ready = (!m.valid || out_ready) && !m_haz;
      #1;
      check("rnd_rs", {rs1, rs2, rs3}, {rd_ref.rs1, rd_ref.rs2, rd_ref.rs3});
      check("rnd_in_ready", 32'(in_ready), 32'(m_ready));
      if (m_haz && out_ready) m_stall++;
      if (in_valid && m_ready)
        m = '{valid: 1'b1, d: rd_ref, a: s1, b: s2, c: s3, pc: in_pc, instr: in_instr};
      else if (!m.valid || out_ready)
        m.valid = 1'b0;
      tick();
      check("rnd_valid", 32'(out_valid), 32'(m.valid));
      check("rnd_stall", 32'(stall_cnt), 32'(m_stall));
      if (m.valid) begin
        check("rnd_a", out_a, m.a);
        check("rnd_b", out_b, m.b);
        check("rnd_c", out_c, m.c);
        check("rnd_imm", out_imm, m.d.imm);
        check("rnd_pc", out_pc, m.pc);
        check("rnd_ctl", {out_rd, out_opcode, out_func, out_is_load, out_is_store},
              {m.d.rd, m.instr[31:26], m.instr[5:0], m.d.ld, m.d.st});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
